cpu_bus_responder: RTL and testbench

Target-side bus responder for the 65C816 core. It accepts CPU bus cycles (24-bit bank:address, read/write) and stalls the core through CPU_EN, the clock-enable that gates the core's address generator and register file. It forwards each cycle to a backend memory port over a req/ack handshake and enforces region-dependent minimum wait states: fast RAM versus the slow Mega II banks $E0/$E1. It returns read data to the core on the completion cycle.

---
 rtl/cpu_bus_responder.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder
//
// Target-side bus responder for the 65C816 core. A CPU bus cycle is captured,
// forwarded to a backend memory port over a req/ack handshake, and held until
// both the backend has acknowledged and a region-dependent minimum number of
// wait states has elapsed. The core is stalled through CPU_EN meanwhile.
// Banks $E0/$E1 (Mega II) use SLOW_WAIT; every other bank uses FAST_WAIT.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : an ACCESS phase without an ACK is forced to complete after
//               TIMEOUT cycles; reads return 8'hFF and TIMEOUT_ERR pulses.
//   Undefined : ACCESS waits indefinitely for MEM_ACK; TIMEOUT_ERR is 0.
//
// Ports
//   CLK, RST_N      clock, asynchronous active-low reset
//   REQ, WE         CPU cycle valid (held until CPU_EN=1), 1=write
//   ADDR, WDATA     CPU {bank,address} and write data
//   RDATA           registered read data to CPU
//   CPU_EN          core clock-enable (combinational), 0 stalls the core
//   MEM_REQ/WE      registered backend request / write strobe
//   MEM_ADDR/WDATA  registered backend address / write data
//   MEM_ACK/RDATA   backend acknowledge and read data
//   SLOW_CYC        captured cycle targets bank $E0/$E1
//   TIMEOUT_ERR     one-cycle pulse on forced completion
// -----------------------------------------------------------------------------
module cpu_bus_responder #(
    parameter int FAST_WAIT = 0,
    parameter int SLOW_WAIT = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic [23:0] ADDR,
    input  logic [7:0]  WDATA,
    output logic [7:0]  RDATA,
    output logic        CPU_EN,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [23:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA,
    output logic        SLOW_CYC,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LP_FAST = 4'(FAST_WAIT);
    localparam logic [3:0] LP_SLOW = 4'(SLOW_WAIT);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wcnt;
    logic        r_ack_seen;
    logic [7:0]  r_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [23:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_slow;

    logic        w_slow;
    logic        w_ack_any;
    logic        w_tmo;

    // Banks $E0 and $E1 differ only in ADDR[16].
    assign w_slow    = (ADDR[23:17] == 7'b1110000);
    // An ACK in the current cycle counts as seen for the exit decision.
    assign w_ack_any = r_ack_seen | MEM_ACK;

`ifdef BUS_TIMEOUT_EN
    localparam logic [6:0] LP_TMO_LAST = 7'(TIMEOUT - 1);

    logic [6:0] r_tcnt;
    logic       r_tmo_err;

    // Only fires if no ACK has been (or is being) seen this transaction.
    assign w_tmo = (r_state == S_ACCESS) && !w_ack_any && (r_tcnt == LP_TMO_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tcnt    <= 7'd0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_tmo;
            if (r_state == S_IDLE) begin
                r_tcnt <= 7'd0;
            end else if (r_state == S_ACCESS) begin
                r_tcnt <= r_tcnt + 7'd1;
            end
        end
    end

    assign TIMEOUT_ERR = r_tmo_err;
`else
    assign w_tmo       = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        CPU_EN = 1'b0;
        case (r_state)
            S_IDLE: begin
                CPU_EN = !REQ;
                if (REQ) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Exit uses the counter value before this cycle's decrement.
                if (w_tmo || (w_ack_any && (r_wcnt == 4'd0))) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                CPU_EN = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wcnt      <= 4'd0;
            r_ack_seen  <= 1'b0;
            r_rdata     <= 8'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 24'd0;
            r_mem_wdata <= 8'd0;
            r_slow      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_mem_addr  <= ADDR;
                        r_mem_we    <= WE;
                        r_mem_wdata <= WDATA;
                        r_mem_req   <= 1'b1;
                        r_slow      <= w_slow;
                        r_wcnt      <= w_slow ? LP_SLOW : LP_FAST;
                        r_ack_seen  <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                    // Only the first ACK is taken; later pulses (or a held
                    // ACK) must not overwrite the captured read data.
                    if (MEM_ACK && !r_ack_seen) begin
                        r_ack_seen <= 1'b1;
                        r_mem_req  <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata <= MEM_RDATA;
                        end
                    end else if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata <= 8'hFF;
                        end
                    end
                end
                S_DONE: begin
                    r_mem_we <= 1'b0;
                    r_slow   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign RDATA     = r_rdata;
    assign MEM_REQ   = r_mem_req;
    assign MEM_WE    = r_mem_we;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign SLOW_CYC  = r_slow;

    // Wait counters are 4 bits wide and the timeout counter is 7 bits wide.
    a_params: assert property (@(posedge CLK)
        (FAST_WAIT >= 0) && (FAST_WAIT <= 15) &&
        (SLOW_WAIT >= 0) && (SLOW_WAIT <= 15) &&
        (TIMEOUT >= 1) && (TIMEOUT <= 128));

endmodule

// File: tb/tb_cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_responder
//
// Directed testbench for cpu_bus_responder (FAST_WAIT=0, SLOW_WAIT=3,
// TIMEOUT=64). Inputs are driven on the falling edge, outputs sampled 1 ns
// later. The timeout case is compiled only when BUS_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_cpu_bus_responder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic [23:0] ADDR = 24'd0;
    logic [7:0]  WDATA = 8'd0;
    logic [7:0]  RDATA;
    logic        CPU_EN;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [23:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_ACK = 1'b0;
    logic [7:0]  MEM_RDATA = 8'd0;
    logic        SLOW_CYC;
    logic        TIMEOUT_ERR;

    int n_chk  = 0;
    int n_pass = 0;

    // results of the most recent txn()
    int          t_en_low, t_req_hi, t_tmo_n;
    logic        t_done, t_en_after, t_slow, t_slow_after, t_mwe, t_mwe_after;
    logic [7:0]  t_rd_done, t_rd_after, t_mwd;
    logic [23:0] t_maddr;

    always #5 CLK = ~CLK;

    cpu_bus_responder #(
        .FAST_WAIT (0),
        .SLOW_WAIT (3),
        .TIMEOUT   (64)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ         (REQ),
        .WE          (WE),
        .ADDR        (ADDR),
        .WDATA       (WDATA),
        .RDATA       (RDATA),
        .CPU_EN      (CPU_EN),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA),
        .SLOW_CYC    (SLOW_CYC),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One CPU cycle. Cycle index 0 is the capture (IDLE) cycle, 1 is the first
    // ACCESS cycle. MEM_ACK is high in cycles ack_at and ack2_at (-1 = never).
    // ADDR/WDATA are scrambled from cycle 2 on to show they are not re-sampled.
    task automatic txn(input logic we, input logic [23:0] a, input logic [7:0] wd,
                       input int ack_at, input int ack2_at,
                       input logic [7:0] rd1, input logic [7:0] rd2);
        t_en_low = 0; t_req_hi = 0; t_tmo_n = 0; t_done = 1'b0;
        @(negedge CLK);
        REQ = 1'b1; WE = we; ADDR = a; WDATA = wd;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (cyc == 2) begin ADDR = ~a; WDATA = ~wd; end
            MEM_ACK   = (cyc == ack_at) || (cyc == ack2_at);
            MEM_RDATA = (cyc == ack_at) ? rd1 : (cyc == ack2_at) ? rd2 : 8'hEE;
            #1;
            if (TIMEOUT_ERR) t_tmo_n++;
            if (CPU_EN) begin
                t_done = 1'b1; t_rd_done = RDATA; t_maddr = MEM_ADDR;
                t_mwe = MEM_WE; t_mwd = MEM_WDATA; t_slow = SLOW_CYC;
                break;
            end
            t_en_low++;
            if (MEM_REQ) t_req_hi++;
        end
        REQ = 1'b0;
        chk("txn_bound", {31'd0, t_done}, 32'd1);
        @(negedge CLK);
        MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
        #1;
        if (TIMEOUT_ERR) t_tmo_n++;
        t_en_after = CPU_EN; t_rd_after = RDATA;
        t_slow_after = SLOW_CYC; t_mwe_after = MEM_WE;
    endtask

    initial begin
        // ---- reset state
        #2;
        chk("rst_rdata",   {24'd0, RDATA}, 32'd0);
        chk("rst_mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst_cpu_en",  {31'd0, CPU_EN}, 32'd1);
        chk("rst_tmo",     {31'd0, TIMEOUT_ERR}, 32'd0);
        @(negedge CLK); RST_N = 1'b1;

        // ---- fast read, ACK in first ACCESS cycle
        txn(1'b0, 24'h00_1234, 8'h00, 1, -1, 8'hA5, 8'h00);
        chk("rd_en_low",  t_en_low, 2);
        chk("rd_req_hi",  t_req_hi, 1);
        chk("rd_maddr",   {8'd0, t_maddr}, 32'h001234);
        chk("rd_rdata",   {24'd0, t_rd_done}, 32'hA5);
        chk("rd_slow",    {31'd0, t_slow}, 32'd0);
        chk("rd_en_idle", {31'd0, t_en_after}, 32'd1);

        // ---- slow write to $E1, ACK in first ACCESS cycle, 4 ACCESS cycles
        txn(1'b1, 24'hE1_C030, 8'h5A, 1, -1, 8'h99, 8'h00);
        chk("wr_en_low",     t_en_low, 5);
        chk("wr_req_hi",     t_req_hi, 1);
        chk("wr_slow",       {31'd0, t_slow}, 32'd1);
        chk("wr_mwe",        {31'd0, t_mwe}, 32'd1);
        chk("wr_mwdata",     {24'd0, t_mwd}, 32'h5A);
        chk("wr_maddr",      {8'd0, t_maddr}, 32'hE1C030);
        chk("wr_rdata_keep", {24'd0, t_rd_done}, 32'hA5);
        chk("wr_slow_clr",   {31'd0, t_slow_after}, 32'd0);
        chk("wr_mwe_clr",    {31'd0, t_mwe_after}, 32'd0);

        // ---- fast read bank $02, ACK delayed 5 cycles, extra ACK during DONE
        txn(1'b0, 24'h02_8000, 8'h00, 6, 7, 8'h77, 8'h88);
        chk("dly_en_low", t_en_low, 7);
        chk("dly_req_hi", t_req_hi, 6);
        chk("dly_rdata",  {24'd0, t_rd_done}, 32'h77);
        chk("dly_rd_keep",{24'd0, t_rd_after}, 32'h77);

        // ---- slow read $E0, ACK held two cycles: second cycle ignored
        txn(1'b0, 24'hE0_0010, 8'h00, 1, 2, 8'h3C, 8'hC3);
        chk("ack2_en_low", t_en_low, 5);
        chk("ack2_rdata",  {24'd0, t_rd_done}, 32'h3C);
        chk("ack2_slow",   {31'd0, t_slow}, 32'd1);

        // ---- reset while a slow write is pending in ACCESS
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; ADDR = 24'hE0_0100; WDATA = 8'h11;
        @(negedge CLK); #1;
        chk("ar_pre_req", {31'd0, MEM_REQ}, 32'd1);
        RST_N = 1'b0; REQ = 1'b0; #1;
        chk("ar_mem_req", {31'd0, MEM_REQ}, 32'd0);
        chk("ar_maddr",   {8'd0, MEM_ADDR}, 32'd0);
        chk("ar_mwe",     {31'd0, MEM_WE}, 32'd0);
        chk("ar_mwdata",  {24'd0, MEM_WDATA}, 32'd0);
        chk("ar_slow",    {31'd0, SLOW_CYC}, 32'd0);
        chk("ar_rdata",   {24'd0, RDATA}, 32'd0);
        chk("ar_cpu_en",  {31'd0, CPU_EN}, 32'd1);
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK); #1;
        chk("ar_idle_en", {31'd0, CPU_EN}, 32'd1);

        // ---- bank boundaries
        txn(1'b0, 24'hDF_FFFF, 8'h00, 1, -1, 8'h01, 8'h00);
        chk("bDF_slow",   {31'd0, t_slow}, 32'd0);
        chk("bDF_en_low", t_en_low, 2);
        chk("bDF_rdata",  {24'd0, t_rd_done}, 32'h01);
        txn(1'b0, 24'hE0_0000, 8'h00, 1, -1, 8'h02, 8'h00);
        chk("bE0_slow",   {31'd0, t_slow}, 32'd1);
        chk("bE0_en_low", t_en_low, 5);
        txn(1'b0, 24'hE1_FFFF, 8'h00, 1, -1, 8'h03, 8'h00);
        chk("bE1_slow",   {31'd0, t_slow}, 32'd1);
        txn(1'b0, 24'hE2_0000, 8'h00, 1, -1, 8'h04, 8'h00);
        chk("bE2_slow",   {31'd0, t_slow}, 32'd0);
        chk("bE2_en_low", t_en_low, 2);
        chk("bE2_tmo",    t_tmo_n, 0);

`ifdef BUS_TIMEOUT_EN
        // ---- read that is never acknowledged
        txn(1'b0, 24'h03_0000, 8'h00, -1, -1, 8'h00, 8'h00);
        chk("to_en_low", t_en_low, 65);
        chk("to_req_hi", t_req_hi, 64);
        chk("to_rdata",  {24'd0, t_rd_done}, 32'hFF);
        chk("to_pulses", t_tmo_n, 1);
        chk("to_mem_req",{31'd0, MEM_REQ}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
